// File: rtl/branch_flag_unit.sv
// Byte-serial A - B with rippled borrow; registers compare flags and the
// RV32I branch-taken decision after four subtract cycles.
module branch_flag_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  funct3,
    output logic        busy,
    output logic        done,
    output logic [31:0] diff,
    output logic        A_S,
    output logic        B_S,
    output logic        S_S,
    output logic        EQ,
    output logic        lt,
    output logic        ltu,
    output logic        taken
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ACC_W  = DATA_W - BYTE_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUB  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state, state_next;
    logic              accept_c, last_c;

    logic [DATA_W-1:0] a_q, b_q;
    logic [2:0]        f3_q;
    logic [1:0]        k;
    logic              borrow;
    logic [ACC_W-1:0]  diff_acc;

    logic [4:0]        byte_sel_c;
    logic [BYTE_W-1:0] a_byte_c, b_byte_c;
    logic [BYTE_W:0]   sub_c;
    logic [DATA_W-1:0] diff_full_c;
    logic              s_s_c, eq_c, lt_c, ltu_c, taken_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and handshake decode
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        last_c     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_c   = 1'b1;
                    state_next = SUB;
                end
            end
            SUB: begin
                if (k == 2'd3) begin
                    last_c     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept_c   = 1'b1;
                    state_next = SUB;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One byte of the subtract per cycle; borrow ripples through a register
    always_comb begin
        byte_sel_c  = {k, 3'b000};
        a_byte_c    = a_q[byte_sel_c +: BYTE_W];
        b_byte_c    = b_q[byte_sel_c +: BYTE_W];
        sub_c       = {1'b0, a_byte_c} - {1'b0, b_byte_c} - 9'(borrow);
        diff_full_c = {sub_c[BYTE_W-1:0], diff_acc};
        s_s_c       = diff_full_c[DATA_W-1];
        eq_c        = (diff_full_c == '0);
        ltu_c       = sub_c[BYTE_W];
        lt_c        = (a_q[DATA_W-1] & ~b_q[DATA_W-1])
                    | (~eq_c & s_s_c & (~b_q[DATA_W-1] | a_q[DATA_W-1]));
        case (f3_q)
            3'b000:  taken_c = eq_c;
            3'b001:  taken_c = ~eq_c;
            3'b100:  taken_c = lt_c;
            3'b101:  taken_c = ~lt_c;
            3'b110:  taken_c = ltu_c;
            3'b111:  taken_c = ~ltu_c;
            default: taken_c = 1'b0;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            f3_q     <= '0;
            k        <= '0;
            borrow   <= 1'b0;
            diff_acc <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            A_S      <= 1'b0;
            B_S      <= 1'b0;
            S_S      <= 1'b0;
            EQ       <= 1'b0;
            lt       <= 1'b0;
            ltu      <= 1'b0;
            taken    <= 1'b0;
        end else begin
            if (accept_c) begin
                a_q    <= A;
                b_q    <= B;
                f3_q   <= funct3;
                k      <= '0;
                borrow <= 1'b0;
            end else if (state == SUB) begin
                k        <= k + 2'd1;
                borrow   <= sub_c[BYTE_W];
                // Low bytes shift in from the top; three shifts leave {b2,b1,b0}
                diff_acc <= {sub_c[BYTE_W-1:0], diff_acc[ACC_W-1:BYTE_W]};
            end
            if (last_c) begin
                diff  <= diff_full_c;
                A_S   <= a_q[DATA_W-1];
                B_S   <= b_q[DATA_W-1];
                S_S   <= s_s_c;
                EQ    <= eq_c;
                lt    <= lt_c;
                ltu   <= ltu_c;
                taken <= taken_c;
            end
            busy <= (state_next == SUB);
            done <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed bench for branch_flag_unit: flags, latency, handshake and reset abort.
module tb_branch_flag_unit;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] A, B;
    logic [2:0]  funct3;
    logic        busy, done, A_S, B_S, S_S, EQ, lt, ltu, taken;
    logic [31:0] diff;

    int total = 0;
    int bad   = 0;

    branch_flag_unit dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .funct3(funct3),
        .busy(busy), .done(done), .diff(diff), .A_S(A_S), .B_S(B_S), .S_S(S_S),
        .EQ(EQ), .lt(lt), .ltu(ltu), .taken(taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return 32'({A_S, B_S, S_S, EQ, lt, ltu, taken});
    endfunction

    // One isolated operation from IDLE; checks latency, results and the single-cycle done
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic [31:0] exp_diff,
                         input logic [6:0] exp_flags);
        @(negedge clk);
        start = 1'b1; A = a; B = b; funct3 = f3;
        @(posedge clk); #1;
        check({tag, ".busy0"}, 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0; A = ~a; B = ~b; funct3 = ~f3;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (i < 4) begin
                check({tag, ".early_done"}, 32'(done), 32'd0);
            end else begin
                check({tag, ".done"}, 32'(done), 32'd1);
                check({tag, ".busy_in_done"}, 32'(busy), 32'd0);
            end
        end
        check({tag, ".diff"}, diff, exp_diff);
        check({tag, ".flags"}, flags(), 32'(exp_flags));
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".diff_hold"}, diff, exp_diff);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; A = '0; B = '0; funct3 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.diff", diff, 32'd0);
        check("reset.flags", flags(), 32'd0);
        check("reset.busy_done", 32'({busy, done}), 32'd0);
        @(negedge clk) reset = 1'b0;

        // flags order: {A_S,B_S,S_S,EQ,lt,ltu,taken}
        do_op("equal",    32'h8000_0000, 32'h8000_0000, 3'b000, 32'h0000_0000, 7'b1101001);
        do_op("mixed_lt", 32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 32'hFFFF_FFFE, 7'b1010101);
        do_op("mixed_lu", 32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 32'hFFFF_FFFE, 7'b1010100);
        do_op("ovf_bge",  32'h7FFF_FFFF, 32'h8000_0000, 3'b101, 32'hFFFF_FFFF, 7'b0110011);
        do_op("ripple",   32'h0000_0100, 32'h0000_0001, 3'b001, 32'h0000_00FF, 7'b0000001);
        do_op("f3_010",   32'h0000_0005, 32'h0000_0003, 3'b010, 32'h0000_0002, 7'b0000000);
        do_op("bgeu",     32'h0000_0003, 32'h0000_0005, 3'b111, 32'hFFFF_FFFE, 7'b0010110);

        // start held high: accept, ignore during SUB, re-accept in DONE cycle
        @(negedge clk);
        start = 1'b1; A = 32'd5; B = 32'd3; funct3 = 3'b000;
        @(posedge clk);
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(posedge clk); #1;
            check($sformatf("hs.done%0d", cyc), 32'(done), 32'((cyc == 4) || (cyc == 9)));
            if (cyc == 4) check("hs.diff1", diff, 32'd2);
            if (cyc == 6) check("hs.diff_hold", diff, 32'd2);
            if (cyc == 9) begin
                check("hs.diff2", diff, 32'hFFFF_FFF6);
                check("hs.flags2", flags(), 32'(7'b0010111));
            end
            @(negedge clk);
            if (cyc == 4) begin
                A = 32'd10; B = 32'd20; funct3 = 3'b110;
            end else begin
                A = 32'hDEAD_BEEF; B = 32'h1234_5678; funct3 = 3'b001;
            end
            if (cyc == 9) start = 1'b0;
        end
        @(posedge clk); #1;
        check("hs.idle", 32'({busy, done}), 32'd0);

        // Reset while byte 2 is being computed
        @(negedge clk);
        start = 1'b1; A = 32'h1234_5678; B = 32'h0101_0101; funct3 = 3'b101;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid.diff", diff, 32'd0);
        check("rst_mid.flags", flags(), 32'd0);
        check("rst_mid.busy_done", 32'({busy, done}), 32'd0);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("rst_mid.no_done", 32'(done), 32'd0);
        end
        do_op("post_rst", 32'h1234_5678, 32'h0101_0101, 3'b101, 32'h1133_5577, 7'b0000001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
